// File: rtl/aes_round_iter_if.sv
// Handshake and data bundle between the iterative AES round core and its
// upstream source (plaintext/key) and downstream final round.
interface aes_round_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] cipherkey;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic [127:0] key_out;
    logic [3:0]   rc_out;

    modport master (
        output in_valid, plaintext, cipherkey, out_ready,
        input  in_ready, out_valid, state_out, key_out, rc_out
    );

    modport slave (
        input  in_valid, plaintext, cipherkey, out_ready,
        output in_ready, out_valid, state_out, key_out, rc_out
    );
endinterface

// File: rtl/aes_round_iter.sv
// Iterative AES-128 core: initial AddRoundKey plus rounds 1..9, one round per
// clock, presenting the round-9 state and key to a downstream final round.
module aes_round_iter (
    input  logic            clk,
    input  logic            rst_n,
    aes_round_iter_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]   fsm_q, fsm_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rkey_q, rkey_d;
    logic         rdy_en_q;
    logic         accept;
    logic         rnd_ok;
    logic [127:0] key_nxt;
    logic [127:0] state_nxt;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] r;
        r = '0;
        p = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ p;
            p = xtime(p);
        end
        return r;
    endfunction

    // S-box as GF(2^8) inverse (x^254, which also maps 0 to 0) then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] sq;
        inv = 8'h01;
        sq  = x;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i != 0) inv = gmul(inv, sq);
            sq = gmul(sq, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rcon);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Byte 4*c+r is row r of column c; byte 0 sits in [127:120].
    function automatic logic [127:0] round_f(input logic [127:0] s);
        logic [7:0]   sb [16];
        logic [7:0]   sr [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        o = '0;
        for (int unsigned i = 0; i < 16; i++) sb[i] = sbox(s[127 - 8*i -: 8]);
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
                sr[4*c + r] = sb[4*((c + r) & 3) + r];
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c + 1];
            a2 = sr[4*c + 2];
            a3 = sr[4*c + 3];
            o[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                   a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                   a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                   xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    assign key_nxt   = expand(rkey_q, rcon_of(rnd_q));
    assign state_nxt = round_f(state_q) ^ key_nxt;
    assign rnd_ok    = (rnd_q >= 4'd1) && (rnd_q <= 4'd9);

    // rdy_en_q keeps in_ready low through reset and until the first clock edge after release.
    assign bus.in_ready  = rdy_en_q & ((fsm_q == IDLE) | ((fsm_q == HOLD) & bus.out_ready));
    assign bus.out_valid = (fsm_q == HOLD);
    assign bus.state_out = state_q;
    assign bus.key_out   = rkey_q;
    assign bus.rc_out    = 4'd10;
    assign accept        = bus.in_valid & bus.in_ready;

    always_comb begin
        fsm_d   = fsm_q;
        rnd_d   = rnd_q;
        state_d = state_q;
        rkey_d  = rkey_q;
        if (accept) begin
            fsm_d   = ROUND;
            rnd_d   = 4'd1;
            state_d = bus.plaintext ^ bus.cipherkey;
            rkey_d  = bus.cipherkey;
        end else begin
            case (fsm_q)
                IDLE: ;
                ROUND: begin
                    if (!rnd_ok) begin
                        fsm_d = IDLE;
                    end else begin
                        state_d = state_nxt;
                        rkey_d  = key_nxt;
                        if (rnd_q == 4'd9) fsm_d = HOLD;
                        else               rnd_d = rnd_q + 4'd1;
                    end
                end
                HOLD: if (bus.out_ready) fsm_d = IDLE;
                default: fsm_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q    <= IDLE;
            rnd_q    <= '0;
            state_q  <= '0;
            rkey_q   <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            rnd_q    <= rnd_d;
            state_q  <= state_d;
            rkey_q   <= rkey_d;
            rdy_en_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_aes_round_iter.sv
// Self-checking bench for aes_round_iter: directed FIPS-197 cases plus random
// traffic checked against a byte-level AES reference model.
module tb_aes_round_iter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_round_iter_if bus();
    aes_round_iter dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ST9_B = 128'heb40f21e592e38848ba113e71bc342d2;
    localparam logic [127:0] K9_B  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [7:0]   sbox_t [256];
    logic [255:0] out_q [$];
    logic [255:0] exp_q [$];
    int           acc_cyc [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && bus.in_valid && bus.in_ready) acc_cyc.push_back(cyc);
        if (rst_n && bus.out_valid && bus.out_ready) out_q.push_back({bus.state_out, bus.key_out});
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        check(tag, 256'(obs), 256'(exp));
    endtask

    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        check(tag, {128'h0, obs}, {128'h0, exp});
    endtask

    function automatic logic [7:0] mul2(input logic [7:0] b);
        return (b << 1) ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [127:0] kexp(input logic [127:0] k, input logic [7:0] rc);
        logic [7:0] w [16];
        logic [7:0] t [4];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) w[i] = k[127 - 8*i -: 8];
        t[0] = sbox_t[w[13]] ^ rc;
        t[1] = sbox_t[w[14]];
        t[2] = sbox_t[w[15]];
        t[3] = sbox_t[w[12]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                w[4*c + r] = w[4*c + r] ^ ((c == 0) ? t[r] : w[4*(c - 1) + r]);
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = w[i];
        return o;
    endfunction

    function automatic logic [127:0] round_model(input logic [127:0] st, input logic [127:0] rk, input bit mix);
        logic [7:0] a [16];
        logic [7:0] b [16];
        logic [7:0] x [4];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sbox_t[st[127 - 8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[4*c + r] = a[4*((c + r) % 4) + r];
        if (mix) begin
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) x[r] = b[4*c + r];
                for (int r = 0; r < 4; r++)
                    b[4*c + r] = mul2(x[r]) ^ mul2(x[(r + 1) % 4]) ^ x[(r + 1) % 4]
                               ^ x[(r + 2) % 4] ^ x[(r + 3) % 4];
            end
        end
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = b[i];
        return o ^ rk;
    endfunction

    function automatic logic [255:0] model9(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] st;
        logic [127:0] rk;
        logic [7:0]   rc;
        st = pt ^ key;
        rk = key;
        rc = 8'h01;
        for (int r = 1; r <= 9; r++) begin
            rk = kexp(rk, rc);
            st = round_model(st, rk, 1'b1);
            rc = mul2(rc);
        end
        return {st, rk};
    endfunction

    function automatic logic [127:0] final_round(input logic [127:0] st, input logic [127:0] k9);
        return round_model(st, kexp(k9, 8'h36), 1'b0);
    endfunction

    task automatic send(input logic [127:0] pt, input logic [127:0] k);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.plaintext = pt;
        bus.cipherkey = k;
        #1;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 100) chk1("accept_wait", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 1;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [7:0]   p, q, x;
        logic [127:0] va, vb, vc, vd;
        logic [255:0] hold_v;
        int           n, o0, a0;
        bit           seen;

        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ mul2(p);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.plaintext = '0;
        bus.cipherkey = '0;

        // Reset state
        #12;
        chk128("rst_state_out", bus.state_out, '0);
        chk128("rst_key_out", bus.key_out, '0);
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chk1("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_rc_out", 256'(bus.rc_out), 256'(4'd10));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk1("ready_after_reset", bus.in_ready, 1'b1);

        // FIPS-197 Appendix B
        send(PT_B, KEY_B);
        wait_out(n);
        check("appb_latency", 256'(n), 256'(10));
        chk128("appb_state", bus.state_out, ST9_B);
        chk128("appb_key", bus.key_out, K9_B);
        check("appb_rc", 256'(bus.rc_out), 256'(4'd10));
        chk128("appb_final_ct", final_round(bus.state_out, bus.key_out), CT_B);
        @(posedge clk);
        #1;
        chk1("appb_valid_falls", bus.out_valid, 1'b0);

        // Backpressure
        @(negedge clk);
        bus.out_ready = 1'b0;
        send(PT_B, KEY_B);
        wait_out(n);
        chk1("bp_valid", bus.out_valid, 1'b1);
        hold_v = {bus.state_out, bus.key_out};
        check("bp_value", hold_v, {ST9_B, K9_B});
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk1("bp_hold_valid", bus.out_valid, 1'b1);
            chk1("bp_hold_in_ready", bus.in_ready, 1'b0);
            check("bp_hold_data", {bus.state_out, bus.key_out}, hold_v);
        end
        o0 = out_q.size();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("bp_one_handshake", 256'(out_q.size() - o0), 256'(1));
        chk1("bp_valid_after", bus.out_valid, 1'b0);

        // Busy ignore
        va = rand128();
        vb = rand128();
        send(va, vb);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.plaintext = rand128();
            bus.cipherkey = rand128();
            #1;
            chk1("busy_in_ready", bus.in_ready, 1'b0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_out(n);
        check("busy_result", {bus.state_out, bus.key_out}, model9(va, vb));
        @(posedge clk);
        #1;

        // Reset mid-operation
        send(PT_B, KEY_B);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk128("midrst_state", bus.state_out, '0);
        chk128("midrst_key", bus.key_out, '0);
        chk1("midrst_valid", bus.out_valid, 1'b0);
        chk1("midrst_in_ready", bus.in_ready, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            seen = seen | bus.out_valid;
        end
        chk1("midrst_no_valid", seen, 1'b0);
        send(PT_B, KEY_B);
        wait_out(n);
        check("midrst_rerun", {bus.state_out, bus.key_out}, {ST9_B, K9_B});
        @(posedge clk);
        #1;

        // Back-to-back with in_valid held high
        va = rand128(); vb = rand128(); vc = rand128(); vd = rand128();
        a0 = acc_cyc.size();
        o0 = out_q.size();
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.plaintext = va;
        bus.cipherkey = vb;
        n = 0;
        while (acc_cyc.size() <= a0 && n < 50) begin @(posedge clk); #1; n++; end
        @(negedge clk);
        bus.plaintext = vc;
        bus.cipherkey = vd;
        n = 0;
        while (acc_cyc.size() <= a0 + 1 && n < 50) begin @(posedge clk); #1; n++; end
        bus.in_valid = 1'b0;
        check("b2b_accepts", 256'(acc_cyc.size() - a0), 256'(2));
        if (acc_cyc.size() >= a0 + 2)
            check("b2b_spacing", 256'(acc_cyc[a0 + 1] - acc_cyc[a0]), 256'(10));
        n = 0;
        while (out_q.size() < o0 + 2 && n < 50) begin @(posedge clk); #1; n++; end
        check("b2b_outputs", 256'(out_q.size() - o0), 256'(2));
        if (out_q.size() >= o0 + 2) begin
            check("b2b_result0", out_q[o0], model9(va, vb));
            check("b2b_result1", out_q[o0 + 1], model9(vc, vd));
        end

        // Random traffic with random backpressure
        out_q.delete();
        exp_q.delete();
        for (int t = 0; t < 1000; t++) begin
            va = rand128();
            vb = rand128();
            @(negedge clk);
            bus.in_valid  = 1'b1;
            bus.plaintext = va;
            bus.cipherkey = vb;
            bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            n = 0;
            while (!bus.in_ready && n < 200) begin
                @(negedge clk);
                bus.out_ready = 1'($urandom_range(0, 1));
                #1;
                n++;
            end
            if (n >= 200) chk1("rand_accept_wait", bus.in_ready, 1'b1);
            @(posedge clk);
            exp_q.push_back(model9(va, vb));
            #1;
            if ($urandom_range(0, 3) == 0) bus.in_valid = 1'b0;
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (out_q.size() < exp_q.size() && n < 100) begin @(posedge clk); #1; n++; end
        check("rand_count", 256'(out_q.size()), 256'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            check("rand_result", out_q[i], exp_q[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
